// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions for the fetch path.
//   fetch_state_e : fetch sequencer state (IDLE, WAIT, FULL, HALT), 2 bits
//   WORD_W        : machine word width
//   RESET_PC_DEF  : default PC loaded on reset (word-aligned)
package cpu_defs_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_timer.sv
// WAIT-cycle counter for the instruction fetch sequencer.
//   CLK   : rising-edge clock
//   Reset : synchronous active-low reset, clears the count
//   clr   : clear the count (memory answered)
//   inc   : count one more cycle spent waiting
//   tc    : terminal count, high while the count equals TIMEOUT-1;
//           never asserted when TIMEOUT is 0 (timeout disabled)
module fetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      // Wraps harmlessly when the timeout is disabled.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (TIMEOUT != 0) && (cnt_q == TC_VAL);

endmodule

// File: rtl/instr_fetch.sv
// Program counter and instruction-fetch sequencer.
// Fetches the word at curPC over a req/ack memory handshake, presents it
// downstream with valid/ready, and on each accepted instruction either
// moves to nextPC, halts (PCWre low) or flags a misaligned target.
//   CLK, Reset          : clock, synchronous active-low reset
//   PCWre, nextPC       : PC write enable (0 = halt) and next address
//   curPC               : current PC
//   imemReq/Addr/Ack/Data : instruction memory read port
//   instValid/Ready, instr : downstream instruction handshake
//   halted, fetchErr    : stopped indication and sticky error flag
//   instCount           : retired instruction count (wraps)
module instr_fetch
  import cpu_defs_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int                TIMEOUT  = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              PCWre,
  input  logic [WORD_W-1:0] nextPC,
  output logic [WORD_W-1:0] curPC,
  output logic              imemReq,
  output logic [WORD_W-1:0] imemAddr,
  input  logic              imemAck,
  input  logic [WORD_W-1:0] imemData,
  output logic              instValid,
  input  logic              instReady,
  output logic [WORD_W-1:0] instr,
  output logic              halted,
  output logic              fetchErr,
  output logic [WORD_W-1:0] instCount
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] count_q, count_d;

  logic fire;
  logic mem_done;
  logic timer_tc;

  // Handshake outputs come straight from the state register.
  assign imemReq   = (state_q == ST_WAIT);
  assign instValid = (state_q == ST_FULL);
  assign halted    = (state_q == ST_HALT);

  assign fire     = instValid && instReady;
  assign mem_done = imemReq && imemAck;

  fetch_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .CLK  (CLK),
    .Reset(Reset),
    .clr  (mem_done),
    .inc  (imemReq && !imemAck),
    .tc   (timer_tc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_done) begin
          instr_d = imemData;
          state_d = ST_FULL;
        end else if (timer_tc) begin
          // Last allowed waiting cycle ended without an answer.
          err_d   = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_FULL: begin
        // PCWre and nextPC only matter when the instruction is accepted.
        if (fire) begin
          count_d = count_q + 1'b1;
          if (!PCWre) begin
            state_d = ST_HALT;
          end else if (nextPC[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d    = nextPC;
            state_d = ST_WAIT;
          end
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign curPC     = pc_q;
  assign imemAddr  = pc_q;
  assign instr     = instr_q;
  assign fetchErr  = err_q;
  assign instCount = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int T1 = 16;

  logic        clk = 1'b0;
  logic        rst_n, pcwre, ack, ready;
  logic [31:0] next_pc, data;
  logic [31:0] cur_pc, addr, instr, count;
  logic        req, valid, halted, err;

  logic        rst2;
  logic [31:0] cur_pc2, addr2, instr2, count2;
  logic        req2, valid2, halted2, err2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(T1)) dut (
    .CLK(clk), .Reset(rst_n), .PCWre(pcwre), .nextPC(next_pc), .curPC(cur_pc),
    .imemReq(req), .imemAddr(addr), .imemAck(ack), .imemData(data),
    .instValid(valid), .instReady(ready), .instr(instr), .halted(halted),
    .fetchErr(err), .instCount(count)
  );

  instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(0)) dut_nt (
    .CLK(clk), .Reset(rst2), .PCWre(1'b1), .nextPC(32'h0), .curPC(cur_pc2),
    .imemReq(req2), .imemAddr(addr2), .imemAck(1'b0), .imemData(32'h0),
    .instValid(valid2), .instReady(1'b1), .instr(instr2), .halted(halted2),
    .fetchErr(err2), .instCount(count2)
  );

  // Reference model: which phase the fetcher is in and the architectural values.
  // phase: 0 = just reset, 1 = waiting for memory, 2 = holding instr, 3 = stopped
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_count;
  logic        m_err;
  int          m_wait;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    if (!rst_n) begin
      m_phase = 0; m_pc = 32'h0; m_instr = 32'h0; m_err = 1'b0;
      m_count = 32'h0; m_wait = 0;
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: begin
          if (ack) begin
            m_instr = data; m_wait = 0; m_phase = 2;
          end else if (T1 != 0 && m_wait == T1 - 1) begin
            m_err = 1'b1; m_phase = 3;
          end else begin
            m_wait++;
          end
        end
        2: begin
          if (ready) begin
            m_count = m_count + 1;
            if (!pcwre) m_phase = 3;
            else if (next_pc % 4 != 0) begin
              m_err = 1'b1; m_phase = 3;
            end else begin
              m_pc = next_pc; m_phase = 1;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    check("curPC", cur_pc, m_pc);
    check("imemAddr", addr, m_pc);
    check("imemReq", {31'b0, req}, {31'b0, m_phase == 1});
    check("instValid", {31'b0, valid}, {31'b0, m_phase == 2});
    check("halted", {31'b0, halted}, {31'b0, m_phase == 3});
    check("fetchErr", {31'b0, err}, {31'b0, m_err});
    check("instr", instr, m_instr);
    check("instCount", count, m_count);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
  endtask

  logic [31:0] held_instr;
  logic [31:0] tmp;

  initial begin
    rst_n = 1'b0; pcwre = 1'b1; ack = 1'b0; ready = 1'b0;
    next_pc = 32'h0; data = 32'h0; rst2 = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst_req", {31'b0, req}, 32'h0);
    check("rst_pc", cur_pc, 32'h0);
    check("rst_cnt", count, 32'h0);

    // Streaming fetch with zero-wait memory
    ack = 1'b1; data = 32'h2001_0005; ready = 1'b1; pcwre = 1'b1;
    next_pc = m_pc + 4; tick();
    check("first_req", {31'b0, req}, 32'h1);
    check("first_addr", addr, 32'h0);
    next_pc = m_pc + 4; tick();
    check("first_valid", {31'b0, valid}, 32'h1);
    check("first_instr", instr, 32'h2001_0005);
    next_pc = m_pc + 4; tick();
    check("pc_after_fire1", cur_pc, 32'h4);
    next_pc = m_pc + 4; tick();
    next_pc = m_pc + 4; tick();
    check("pc_after_fire2", cur_pc, 32'h8);
    next_pc = m_pc + 4; tick();
    next_pc = m_pc + 4; tick();
    check("count_after_3", count, 32'd3);
    check("pc_after_fire3", cur_pc, 32'hC);

    // Backpressure in FULL
    data = 32'hDEAD_0001; tick();
    held_instr = instr;
    check("bp_instr", held_instr, 32'hDEAD_0001);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data = $urandom(); next_pc = $urandom(); pcwre = $urandom_range(0, 1);
      tick();
      check("bp_hold_instr", instr, 32'hDEAD_0001);
      check("bp_hold_pc", cur_pc, 32'hC);
      check("bp_no_req", {31'b0, req}, 32'h0);
      check("bp_count", count, 32'd3);
    end
    ready = 1'b1; pcwre = 1'b1; next_pc = m_pc + 4; tick();
    check("bp_release_cnt", count, 32'd4);
    check("bp_release_pc", cur_pc, 32'h10);

    // Halt at 0x10
    data = 32'h1234_5678; tick();
    pcwre = 1'b0; next_pc = 32'h14; tick();
    check("halt_flag", {31'b0, halted}, 32'h1);
    check("halt_pc", cur_pc, 32'h10);
    check("halt_cnt", count, 32'd5);
    for (int i = 0; i < 20; i++) begin
      ack = $urandom_range(0, 1); pcwre = 1'b1; next_pc = $urandom();
      tick();
      check("halt_no_req", {31'b0, req}, 32'h0);
    end
    check("halt_pc_still", cur_pc, 32'h10);

    // Misaligned target
    do_reset();
    ack = 1'b1; ready = 1'b1; pcwre = 1'b1; data = 32'hA5A5_0000;
    tick(); tick();
    next_pc = 32'h0000_0022; tick();
    check("mis_err", {31'b0, err}, 32'h1);
    check("mis_halt", {31'b0, halted}, 32'h1);
    check("mis_pc", cur_pc, 32'h0);

    // Timeout with no memory answer
    do_reset();
    ack = 1'b0;
    for (int i = 1; i <= 16; i++) tick();
    check("to_still_wait", {31'b0, req}, 32'h1);
    check("to_no_err_yet", {31'b0, err}, 32'h0);
    tick();
    check("to_err", {31'b0, err}, 32'h1);
    check("to_halt", {31'b0, halted}, 32'h1);
    check("to_req_low", {31'b0, req}, 32'h0);

    // Reset in WAIT while memory answers at the same edge
    do_reset();
    ack = 1'b0; tick(); tick();
    check("rw_in_wait", {31'b0, req}, 32'h1);
    ack = 1'b1; data = 32'hFFFF_FFFF; rst_n = 1'b0; tick();
    check("rw_instr", instr, 32'h0);
    check("rw_valid", {31'b0, valid}, 32'h0);
    check("rw_pc", cur_pc, 32'h0);
    check("rw_err", {31'b0, err}, 32'h0);
    check("rw_halt", {31'b0, halted}, 32'h0);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 29) != 0);
      pcwre = ($urandom_range(0, 15) != 0);
      ack   = $urandom_range(0, 1);
      ready = $urandom_range(0, 1);
      data  = $urandom();
      tmp   = $urandom();
      case ($urandom_range(0, 9))
        0: next_pc = (tmp[1:0] == 2'b00) ? (tmp | 32'h1) : tmp;
        1, 2: begin tmp[1:0] = 2'b00; next_pc = tmp; end
        default: next_pc = m_pc + 4;
      endcase
      tick();
    end

    // Timeout disabled: second instance must wait indefinitely
    rst_n = 1'b0;
    rst2 = 1'b0; tick();
    rst2 = 1'b1; tick();
    for (int i = 0; i < 1000; i++) begin
      tick();
      check("nt_req", {31'b0, req2}, 32'h1);
      check("nt_err", {31'b0, err2}, 32'h0);
    end
    check("nt_halt", {31'b0, halted2}, 32'h0);
    check("nt_pc", cur_pc2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
